// File: rtl/calc_pkg.sv
// Shared types and constants for the sign-magnitude calculator sequencer.
// Optional divider is enabled by defining CALC_DIV_EN.
package calc_pkg;

  localparam int VAL_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDSUB = 2'd1,
    ITER   = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Front-end to sequencer bundle: switch operands and start/clr in, result and handshake out.
interface calc_op_sequencer_if
  import calc_pkg::*;
#(
  parameter int VAL_W = VAL_W_DEF,
  parameter int RES_W = 2 * VAL_W
);

  logic             start;
  logic             clr;
  logic [VAL_W-1:0] sw_val1;
  logic             sw_sign1;
  logic [VAL_W-1:0] sw_val2;
  logic             sw_sign2;
  logic [1:0]       sw_op;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] res_mag;
  logic             res_sign;
  logic             err;
  logic             disp_en;

  modport master (
    output start, clr, sw_val1, sw_sign1, sw_val2, sw_sign2, sw_op,
    input  busy, done, res_mag, res_sign, err, disp_en
  );

  modport slave (
    input  start, clr, sw_val1, sw_sign1, sw_val2, sw_sign2, sw_op,
    output busy, done, res_mag, res_sign, err, disp_en
  );

endinterface

// File: rtl/calc_iter_unit.sv
// Iterative magnitude engine: shift-add multiply, plus restoring divide when CALC_DIV_EN is defined.
// Outputs present the value the registers take on the current step, so the caller can latch on the last step.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int VAL_W = VAL_W_DEF,
  parameter int RES_W = 2 * VAL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [VAL_W-1:0] opa,
  input  logic [VAL_W-1:0] opb,
  output logic             last,
  output logic [RES_W-1:0] product
`ifdef CALC_DIV_EN
  ,
  output logic [VAL_W-1:0] quotient,
  output logic [VAL_W-1:0] remainder
`endif
);

  localparam int CW = (VAL_W > 1) ? $clog2(VAL_W) : 1;

  logic [RES_W-1:0] acc_q;
  logic [VAL_W-1:0] a_q;
  logic [VAL_W-1:0] b_q;
  logic [CW-1:0]    cnt_q;

  assign last = (cnt_q == CW'(VAL_W - 1));

  always_comb begin
    product = acc_q;
    if (b_q[cnt_q]) product = acc_q + (RES_W'(a_q) << cnt_q);
  end

`ifdef CALC_DIV_EN
  logic [VAL_W-1:0] quo_q;
  logic [VAL_W-1:0] rem_q;
  logic [VAL_W:0]   rem_sh;
  logic [VAL_W:0]   rem_diff;

  // Restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    rem_sh   = {rem_q, quo_q[VAL_W-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    if (rem_sh >= {1'b0, b_q}) begin
      remainder = rem_diff[VAL_W-1:0];
      quotient  = {quo_q[VAL_W-2:0], 1'b1};
    end else begin
      remainder = rem_sh[VAL_W-1:0];
      quotient  = {quo_q[VAL_W-2:0], 1'b0};
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
`ifdef CALC_DIV_EN
      quo_q <= '0;
      rem_q <= '0;
`endif
    end else if (load) begin
      acc_q <= '0;
      a_q   <= opa;
      b_q   <= opb;
      cnt_q <= '0;
`ifdef CALC_DIV_EN
      quo_q <= opa;
      rem_q <= '0;
`endif
    end else if (step) begin
      acc_q <= product;
      cnt_q <= cnt_q + CW'(1);
`ifdef CALC_DIV_EN
      quo_q <= quotient;
      rem_q <= remainder;
`endif
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Operation sequencer for the sign-magnitude calculator: latches switches on start, runs add/sub or
// the iterative unit, and holds the result for the display. Define CALC_DIV_EN to enable op 11 division.
//
//   state  | meaning
//   IDLE   | waiting for start; result registers hold last outcome
//   ADDSUB | single-cycle add/sub on captured operands
//   ITER   | VAL_W steps of the multiply/divide unit
//   FINISH | invalid operation; publish error and zero result
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int VAL_W = VAL_W_DEF,
  parameter int RES_W = 2 * VAL_W
) (
  input  logic clk,
  input  logic rst_n,
  calc_op_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [VAL_W-1:0] val1_q, val2_q;
  logic             sign1_q, sign2_q;
  op_e              op_q;
  logic [RES_W-1:0] res_mag_q, res_mag_d;
  logic             res_sign_q, res_sign_d;
  logic             err_q, err_d;
  logic             disp_q, disp_d;
  logic             done_q, done_d;
  logic             cap_en;
  logic             step;
  logic             last;
  logic [RES_W-1:0] product;
  logic             sign2_eff;
  logic [RES_W-1:0] as_mag;
  logic             as_sign;

`ifdef CALC_DIV_EN
  logic [VAL_W-1:0] quotient, remainder;
`endif

  calc_iter_unit #(.VAL_W(VAL_W), .RES_W(RES_W)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cap_en),
    .step     (step),
    .opa      (bus.sw_val1),
    .opb      (bus.sw_val2),
    .last     (last),
    .product  (product)
`ifdef CALC_DIV_EN
    ,
    .quotient (quotient),
    .remainder(remainder)
`endif
  );

  // Subtraction is addition with operand 2's sign flipped; the larger magnitude sets the sign.
  always_comb begin
    sign2_eff = (op_q == OP_SUB) ? ~sign2_q : sign2_q;
    if (sign1_q == sign2_eff) begin
      as_mag  = RES_W'(val1_q) + RES_W'(val2_q);
      as_sign = sign1_q;
    end else if (val1_q >= val2_q) begin
      as_mag  = RES_W'(val1_q - val2_q);
      as_sign = sign1_q;
    end else begin
      as_mag  = RES_W'(val2_q - val1_q);
      as_sign = sign2_eff;
    end
    if (as_mag == '0) as_sign = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    res_mag_d  = res_mag_q;
    res_sign_d = res_sign_q;
    err_d      = err_q;
    disp_d     = disp_q;
    done_d     = 1'b0;
    cap_en     = 1'b0;
    step       = 1'b0;
    if (bus.clr) begin
      state_d    = IDLE;
      res_mag_d  = '0;
      res_sign_d = 1'b0;
      err_d      = 1'b0;
      disp_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cap_en = 1'b1;
            err_d  = 1'b0;
            case (op_e'(bus.sw_op))
              OP_ADD, OP_SUB: state_d = ADDSUB;
              OP_MUL:         state_d = ITER;
`ifdef CALC_DIV_EN
              default:        state_d = (bus.sw_val2 == '0) ? FINISH : ITER;
`else
              default:        state_d = FINISH;
`endif
            endcase
          end
        end
        ADDSUB: begin
          res_mag_d  = as_mag;
          res_sign_d = as_sign;
          disp_d     = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
        ITER: begin
          step = 1'b1;
          if (last) begin
            res_mag_d  = product;
            res_sign_d = (sign1_q ^ sign2_q) & (product != '0);
`ifdef CALC_DIV_EN
            if (op_q == OP_DIV) begin
              res_mag_d  = RES_W'({remainder, quotient});
              res_sign_d = (sign1_q ^ sign2_q) & (quotient != '0);
            end
`endif
            disp_d  = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          res_mag_d  = '0;
          res_sign_d = 1'b0;
          err_d      = 1'b1;
          disp_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      val1_q     <= '0;
      val2_q     <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      op_q       <= OP_ADD;
      res_mag_q  <= '0;
      res_sign_q <= 1'b0;
      err_q      <= 1'b0;
      disp_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_mag_q  <= res_mag_d;
      res_sign_q <= res_sign_d;
      err_q      <= err_d;
      disp_q     <= disp_d;
      done_q     <= done_d;
      if (cap_en) begin
        val1_q  <= bus.sw_val1;
        val2_q  <= bus.sw_val2;
        sign1_q <= bus.sw_sign1;
        sign2_q <= bus.sw_sign2;
        op_q    <= op_e'(bus.sw_op);
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.res_mag  = res_mag_q;
  assign bus.res_sign = res_sign_q;
  assign bus.err      = err_q;
  assign bus.disp_en  = disp_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: random and directed operations against a signed-integer model.
module tb_calc_op_sequencer;

  localparam int VAL_W = 4;
  localparam int RES_W = 2 * VAL_W;

  typedef struct {
    logic [RES_W-1:0] mag;
    logic             sign;
    logic             err;
    logic             disp;
    int               start_cyc;
    int               lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_op_sequencer_if #(.VAL_W(VAL_W), .RES_W(RES_W)) bus ();

  calc_op_sequencer #(.VAL_W(VAL_W), .RES_W(RES_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Signed-integer reference: operands become plain integers, result sign falls out of the arithmetic.
  function automatic exp_t model(input int v1, input bit s1, input int v2, input bit s2, input int op);
    exp_t e;
    int   a, b, r;
    a = s1 ? -v1 : v1;
    b = s2 ? -v2 : v2;
    r = 0;
    e.err = 1'b0; e.disp = 1'b1; e.lat = 2; e.start_cyc = 0;
    e.mag = '0; e.sign = 1'b0;
    if (op == 0) r = a + b;
    else if (op == 1) r = a - b;
    else if (op == 2) begin r = a * b; e.lat = VAL_W + 1; end
    if (op < 3) begin
      e.mag  = RES_W'((r < 0) ? -r : r);
      e.sign = (r < 0);
    end else begin
`ifdef CALC_DIV_EN
      if (v2 == 0) begin
        e.err = 1'b1; e.disp = 1'b0;
      end else begin
        e.mag  = RES_W'((v1 % v2) * (1 << VAL_W) + (v1 / v2));
        e.sign = (s1 != s2) && ((v1 / v2) != 0);
        e.lat  = VAL_W + 1;
      end
`else
      e.err = 1'b1; e.disp = 1'b0;
`endif
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_mag", 32'(bus.res_mag), 32'(e.mag));
        check("res_sign", 32'(bus.res_sign), 32'(e.sign));
        check("err", 32'(bus.err), 32'(e.err));
        check("disp_en", 32'(bus.disp_en), 32'(e.disp));
        check("busy_at_done", 32'(bus.busy), 0);
        check("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
      end
    end
  end

  task automatic drive_sw(input int v1, input bit s1, input int v2, input bit s2, input int op);
    bus.sw_val1  = VAL_W'(v1);
    bus.sw_sign1 = s1;
    bus.sw_val2  = VAL_W'(v2);
    bus.sw_sign2 = s2;
    bus.sw_op    = 2'(op);
  endtask

  task automatic issue(input int v1, input bit s1, input int v2, input bit s2, input int op);
    exp_t e;
    @(negedge clk);
    drive_sw(v1, s1, v2, s2, op);
    bus.start   = 1'b1;
    e           = model(v1, s1, v2, s2, op);
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    drive_sw(int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 15)),
             1'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) check("idle_timeout", 32'(bus.busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_mag"}, 32'(bus.res_mag), 0);
    check({tag, "_sign"}, 32'(bus.res_sign), 0);
    check({tag, "_err"}, 32'(bus.err), 0);
    check({tag, "_disp"}, 32'(bus.disp_en), 0);
  endtask

  task automatic expect_no_done(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'(bus.done), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    drive_sw(0, 0, 0, 0, 0);
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(9, 0, 9, 0, 0);  wait_idle();
    issue(9, 0, 1, 1, 0);  wait_idle();
    issue(7, 1, 9, 0, 1);  wait_idle();
    issue(1, 0, 1, 0, 1);  wait_idle();

    // Multiply with a second start sampled at edge k+2 that must be ignored.
    issue(9, 0, 9, 1, 2);
    @(negedge clk);
    drive_sw(2, 0, 3, 0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    expect_no_done("no_extra_done", 3);

    issue(5, 0, 3, 0, 3);  wait_idle();
    issue(2, 1, 3, 0, 0);  wait_idle();
`ifdef CALC_DIV_EN
    issue(9, 0, 2, 1, 3);  wait_idle();
    issue(5, 0, 0, 0, 3);  wait_idle();
`endif

    // clr sampled at edge k+2 of a multiply.
    issue(7, 0, 6, 0, 2);
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    void'(sb.pop_back());
    check_all_zero("clr");
    expect_no_done("clr_no_done", 5);

    // start and clr together in IDLE.
    issue(4, 0, 4, 0, 0);  wait_idle();
    @(negedge clk);
    drive_sw(3, 0, 3, 0, 2);
    bus.start = 1'b1;
    bus.clr   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    check_all_zero("start_clr");
    expect_no_done("start_clr_no_done", 6);

    // Asynchronous reset in the middle of a multiply.
    issue(6, 1, 5, 0, 0);  wait_idle();
    issue(8, 0, 7, 1, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(3, 0, 3, 0, 2);  wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 15)),
            1'($urandom), int'($urandom_range(0, 3)));
      wait_idle();
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
